// File: rtl/pc_sequencer.sv
// Program counter plus IF/ID latch: drives the fetch address, captures the returned
// instruction, and handles stall, branch flush, halt and a saturating fetch counter.
module pc_sequencer #(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     INS_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [INS_W-1:0] NOP     = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [PC_W-1:0]  pc,
    input  logic [INS_W-1:0] ins_in,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic             halt,
    output logic [INS_W-1:0] if_ins,
    output logic [PC_W-1:0]  if_pc,
    output logic             if_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;

    // NOTE: all state lives in one clocked block with non-blocking assignments, so
    // every output is a register and the order of statements below cannot race.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            if_ins      <= NOP;
            if_pc       <= '0;
            if_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            unique case (state)
                // One settling cycle for the fetch memory at RESET_PC; stall is ignored here.
                BOOT: begin
                    if (halt) begin
                        state    <= HALT;
                        halted   <= 1'b1;
                        if_valid <= 1'b0;
                        if_ins   <= NOP;
                    end else begin
                        state <= RUN;
                        if (br_taken) begin
                            pc       <= br_target;
                            if_valid <= 1'b0;
                            if_ins   <= NOP;
                        end
                    end
                end

                RUN: begin
                    if (halt) begin
                        state    <= HALT;
                        halted   <= 1'b1;
                        if_valid <= 1'b0;
                        if_ins   <= NOP;
                    end else if (br_taken) begin
                        // Flush wins over stall; the target is always reloaded, even if equal to pc.
                        pc       <= br_target;
                        if_valid <= 1'b0;
                        if_ins   <= NOP;
                    end else if (!stall) begin
                        if_ins   <= ins_in;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + 1'b1;
                        if (fetch_count != '1) begin
                            fetch_count <= fetch_count + 1'b1;
                        end
                    end
                end

                HALT: begin
                    // Terminal: outputs stay frozen until reset.
                end

                default: begin
                    state    <= HALT;
                    halted   <= 1'b1;
                    if_valid <= 1'b0;
                    if_ins   <= NOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch memory returns 0xA0000000 | address.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pc;
    logic [31:0] ins_in;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic        halt = 1'b0;
    logic [31:0] if_ins;
    logic [7:0]  if_pc;
    logic        if_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .ins_in      (ins_in),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halt        (halt),
        .if_ins      (if_ins),
        .if_pc       (if_pc),
        .if_valid    (if_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    assign ins_in = 32'hA000_0000 | {24'h0, pc};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [7:0] exp_pc,
                               input logic [7:0] exp_if_pc, input logic exp_valid,
                               input logic [31:0] exp_ins, input logic [15:0] exp_cnt);
        check({tag, ".pc"},       pc,          exp_pc);
        check({tag, ".if_pc"},    if_pc,       exp_if_pc);
        check({tag, ".if_valid"}, if_valid,    exp_valid);
        check({tag, ".if_ins"},   if_ins,      exp_ins);
        check({tag, ".count"},    fetch_count, exp_cnt);
    endtask

    initial begin
        // Reset state is visible without any clock edge.
        #1;
        check_fetch("reset", 8'h00, 8'h00, 1'b0, 32'h0, 16'd0);
        check("reset.halted", halted, 1'b0);
        #11 rst = 1'b0;

        step();  // BOOT -> RUN, nothing latched yet
        check_fetch("boot", 8'h00, 8'h00, 1'b0, 32'h0, 16'd0);
        step();
        check_fetch("first", 8'h01, 8'h00, 1'b1, 32'hA000_0000, 16'd1);
        step(); step(); step();
        check_fetch("run4", 8'h04, 8'h03, 1'b1, 32'hA000_0003, 16'd4);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_fetch("stall", 8'h04, 8'h03, 1'b1, 32'hA000_0003, 16'd4);
        end
        stall = 1'b0;
        step();
        check_fetch("release", 8'h05, 8'h04, 1'b1, 32'hA000_0004, 16'd5);
        step(); step();
        check_fetch("run7", 8'h07, 8'h06, 1'b1, 32'hA000_0006, 16'd7);

        // Branch while stalled: flush wins.
        stall = 1'b1; br_taken = 1'b1; br_target = 8'h40;
        step();
        check_fetch("br_flush", 8'h40, 8'h06, 1'b0, 32'h0, 16'd7);
        stall = 1'b0; br_taken = 1'b0;
        step();
        check_fetch("br_target", 8'h41, 8'h40, 1'b1, 32'hA000_0040, 16'd8);

        // Wrap from 0xFF to 0x00.
        br_taken = 1'b1; br_target = 8'hFE;
        step();
        check_fetch("wrap_br", 8'hFE, 8'h40, 1'b0, 32'h0, 16'd8);
        br_taken = 1'b0;
        step();
        check_fetch("wrap_fe", 8'hFF, 8'hFE, 1'b1, 32'hA000_00FE, 16'd9);
        step();
        check_fetch("wrap_ff", 8'h00, 8'hFF, 1'b1, 32'hA000_00FF, 16'd10);
        step();
        check_fetch("wrap_00", 8'h01, 8'h00, 1'b1, 32'hA000_0000, 16'd11);
        step();
        check_fetch("wrap_01", 8'h02, 8'h01, 1'b1, 32'hA000_0001, 16'd12);

        br_taken = 1'b1; br_target = 8'h10;
        step();
        check_fetch("to_10", 8'h10, 8'h01, 1'b0, 32'h0, 16'd12);

        // Halt outranks the simultaneous branch.
        halt = 1'b1; br_target = 8'h55;
        step();
        check_fetch("halt", 8'h10, 8'h01, 1'b0, 32'h0, 16'd12);
        check("halt.halted", halted, 1'b1);
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stall = i[0]; br_taken = i[1]; br_target = 8'(8'h20 + i);
            step();
            check_fetch("halt_frozen", 8'h10, 8'h01, 1'b0, 32'h0, 16'd12);
            check("halt_frozen.halted", halted, 1'b1);
        end
        stall = 1'b0; br_taken = 1'b0;

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        check_fetch("async_rst", 8'h00, 8'h00, 1'b0, 32'h0, 16'd0);
        check("async_rst.halted", halted, 1'b0);
        #1 rst = 1'b0;

        // Stall is ignored in BOOT; then redirect to the current pc still flushes.
        stall = 1'b1;
        step();
        check_fetch("boot_stall", 8'h00, 8'h00, 1'b0, 32'h0, 16'd0);
        stall = 1'b0;
        step();
        check_fetch("post_boot", 8'h01, 8'h00, 1'b1, 32'hA000_0000, 16'd1);
        br_taken = 1'b1; br_target = 8'h01;
        step();
        check_fetch("br_same", 8'h01, 8'h00, 1'b0, 32'h0, 16'd1);
        br_taken = 1'b0;
        step();
        check_fetch("br_same_reload", 8'h02, 8'h01, 1'b1, 32'hA000_0001, 16'd2);

        // Branch honoured during BOOT.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        br_taken = 1'b1; br_target = 8'h20;
        step();
        check_fetch("boot_br", 8'h20, 8'h00, 1'b0, 32'h0, 16'd0);
        br_taken = 1'b0;
        step();
        check_fetch("boot_br_fetch", 8'h21, 8'h20, 1'b1, 32'hA000_0020, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
